seg7_ctrl: RTL and testbench
============================

# seg7_ctrl

Upstream companion of the 7-segment scanner in the board I/O path. Accepts a 16-bit hex value plus per-digit decimal-point, blank and blink masks from the CPU-side bus. Produces the active-low segment patterns (`data`), the 2-bit digit-select counter (`scan`) and the blink phase (`flash`) that the scanner consumes. New values commit only at frame boundaries, so the display never shows a half-updated frame.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; must be ≥ 2.
- `FLASH_DIV`, default 128: full 4-digit frames per `flash` half-period; must be ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write request.
- `wr_ready` out 1: write can be accepted; a write is accepted when `wr_en && wr_ready`.
- `wr_data` in 16: hex digits; digit i = `wr_data[4i+3:4i]`.
- `wr_dp` in 4: decimal-point enable per digit.
- `wr_blank` in 4: force digit dark.
- `wr_blink` in 4: digit dark while `flash`=1.
- `scan` out 2: current digit slot, 0..3.
- `flash` out 1: blink phase.
- `data` out 32: segment bytes; slot i byte = `data[31-8i:24-8i]`; bit7 = dp, bits6:0 = g..a; all active-low.

## Operation
- Registers:
  - `div_cnt` counts 0..SCAN_DIV-1.
  - `scan` increments, wrapping 3→0, on the cycle `div_cnt`==SCAN_DIV-1.
  - Frame boundary (`fb`) = `div_cnt`==SCAN_DIV-1 && `scan`==3.
  - `frm_cnt` counts frames 0..FLASH_DIV-1; on `fb` with `frm_cnt`==FLASH_DIV-1 it wraps and `flash` toggles.
- Write path (one-entry pending buffer):
  - On accept, {data, dp, blank, blink} load into the pending buffer and `pend` is set.
  - `wr_ready` = !`pend`.
  - On `fb` with `pend`=1: the pending buffer copies to the committed set and `pend` clears.
  - Accept and `fb` never coincide on the same entry. An accept in an `fb` cycle (only possible with `pend`=0) fills pending and commits at the next `fb`.
- Byte encode per digit i, from committed state, each cycle:
  - If `blank[i]`, or `blink[i]` && `flash`: byte = 8'hFF.
  - Else: byte = {~dp[i], hexseg(d[i])}.
  - `hexseg`, in order 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (bit7 shown as 1, masked to 7 bits).
- `data` is a register loaded every cycle from the encode result.

## Timing
- Reset values:
  - `scan`=0, `flash`=0, `data`=32'hFFFF_FFFF, `wr_ready`=1.
  - `div_cnt`=0, `frm_cnt`=0, `pend`=0.
  - Committed and pending buffers: data 0, all masks 0 except `blank`=4'hF.
- Reset mid-operation: all state returns to reset values immediately. A pending write is discarded.
- Write latency: the committed set updates on the `fb` edge after acceptance. `data` reflects it one cycle later.
- Latency is 1 cycle from committed state or `flash` change to `data`.
- `scan` period is SCAN_DIV cycles per slot, 4·SCAN_DIV per frame.
- `flash` period is 8·SCAN_DIV·FLASH_DIV cycles.
- `wr_en` while `wr_ready`=0 is ignored (no queueing, no error).

## Structure
- Package `seg7_pkg`: `SEG_BLANK` = 8'hFF, the 16-entry hex pattern constant array, and the slot-to-byte index function.
- Sub-module `hex_to_seg7`: combinational, 4-bit nibble + dp → 8-bit active-low byte. Instantiate four times.
- Counters, pending/committed buffers and the output register live in `seg7_ctrl`.

## Test plan
Bench parameters: SCAN_DIV=4, FLASH_DIV=2.
- **Reset**: assert `rst_n`=0 mid-frame → same cycle `scan`=0, `flash`=0, `data`=FFFF_FFFF, `wr_ready`=1.
- **Scan**: free run → `scan` steps 0,1,2,3,0 every 4 cycles; `flash` toggles every 32 cycles.
- **Write**: write 0x1234, masks 0 at cycle 5 → `wr_ready` low from cycle 6 until the `fb` at cycle 15. `data`=32'h99B0A4F9 from cycle 17.
- **Decimal point + blank**: `wr_dp`=4'b0001, `wr_blank`=4'b1000, value 0x1234 → `data`=32'h19B0A4FF after commit.
- **Blink + back-to-back**: `wr_blink`=4'b0010 → byte 1 alternates B0/FF with `flash`. A second `wr_en` while `wr_ready`=0 is dropped; a write in an `fb` cycle commits one frame later.
- **Reset with pending write**: `rst_n` low while `pend`=1 → after release, `data` stays FFFF_FFFF and the write never appears.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment controller:
// the hex glyph table, the dark-byte value and the slot-to-byte mapping.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs for 0..F; bit7 is kept at 1 here and replaced by the dp bit.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } disp_t;

    localparam disp_t DISP_RESET = '{hex: 16'h0000, dp: 4'h0, blank: 4'hF, blink: 4'h0};

    // Slot 0 occupies the most significant byte of the output word.
    function automatic int slot_lsb(input int slot);
        return 24 - 8 * slot;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph encoder producing one active-low segment byte.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] glyph;

    assign glyph = HEX_SEG[nibble];
    assign seg   = {~dp, glyph[6:0]};

endmodule

// File: rtl/seg7_ctrl.sv
// Frame-synchronous 7-segment controller: scan/blink timing, a one-entry
// write buffer that commits only at frame boundaries, and the registered segment word.
module seg7_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_DIV = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    input  logic [3:0]  wr_blink,
    output logic [1:0]  scan,
    output logic        flash,
    output logic [31:0] data
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FLASH_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frm_cnt;
    logic          slot_end;
    logic          fb;
    logic          pend;
    logic          accept;
    disp_t         pend_buf;
    disp_t         com_buf;
    logic [7:0]    seg_byte [4];
    logic [31:0]   data_next;

    assign slot_end = (div_cnt == DIV_LAST);
    assign fb       = slot_end && (scan == 2'd3);
    assign wr_ready = !pend;
    assign accept   = wr_en && !pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            scan    <= 2'd0;
            frm_cnt <= '0;
            flash   <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + DW'(1);
            if (slot_end) begin
                scan <= scan + 2'd1;
            end
            if (fb) begin
                if (frm_cnt == FRM_LAST) begin
                    frm_cnt <= '0;
                    flash   <= ~flash;
                end else begin
                    frm_cnt <= frm_cnt + FW'(1);
                end
            end
        end
    end

    // Accept and commit are exclusive: accept needs pend=0, commit needs pend=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_buf <= DISP_RESET;
            com_buf  <= DISP_RESET;
        end else if (accept) begin
            pend     <= 1'b1;
            pend_buf <= '{hex: wr_data, dp: wr_dp, blank: wr_blank, blink: wr_blink};
        end else if (fb && pend) begin
            pend    <= 1'b0;
            com_buf <= pend_buf;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_enc
        hex_to_seg7 u_enc (
            .nibble (com_buf.hex[4*g +: 4]),
            .dp     (com_buf.dp[g]),
            .seg    (seg_byte[g])
        );
    end

    always_comb begin
        data_next = {4{SEG_BLANK}};
        for (int i = 0; i < 4; i++) begin
            if (!(com_buf.blank[i] || (com_buf.blink[i] && flash))) begin
                data_next[slot_lsb(i) +: 8] = seg_byte[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= {4{SEG_BLANK}};
        end else begin
            data <= data_next;
        end
    end

endmodule

// File: tb/tb_seg7_ctrl.sv
// Randomized and directed bench for seg7_ctrl against a cycle-count based reference model.
module tb_seg7_ctrl;

    localparam int SD         = 4;
    localparam int FD         = 2;
    localparam int FRAME      = 4 * SD;
    localparam int FLASH_HALF = FRAME * FD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  wr_blank = '0;
    logic [3:0]  wr_blink = '0;
    logic [1:0]  scan;
    logic        flash;
    logic [31:0] data;

    int errors = 0;
    int checks = 0;

    seg7_ctrl #(.SCAN_DIV(SD), .FLASH_DIV(FD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .wr_blank (wr_blank),
        .wr_blink (wr_blink),
        .scan     (scan),
        .flash    (flash),
        .data     (data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] h);
        logic [7:0] r;
        r = 8'hC0;
        case (h)
            4'h0: r = 8'hC0;  4'h1: r = 8'hF9;  4'h2: r = 8'hA4;  4'h3: r = 8'hB0;
            4'h4: r = 8'h99;  4'h5: r = 8'h92;  4'h6: r = 8'h82;  4'h7: r = 8'hF8;
            4'h8: r = 8'h80;  4'h9: r = 8'h90;  4'hA: r = 8'h88;  4'hB: r = 8'h83;
            4'hC: r = 8'hC6;  4'hD: r = 8'hA1;  4'hE: r = 8'h86;  4'hF: r = 8'h8E;
            default: r = 8'hC0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] encode(input logic [15:0] hx, input logic [3:0] dp,
                                           input logic [3:0] bl, input logic [3:0] bk,
                                           input logic fl);
        logic [31:0] r;
        logic [7:0]  s;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            s = glyph(hx[4*d +: 4]);
            if (bl[d] || (bk[d] && fl)) r[31-8*d -: 8] = 8'hFF;
            else                        r[31-8*d -: 8] = {~dp[d], s[6:0]};
        end
        return r;
    endfunction

    // Reference model: timing from a cycle count since reset, one pending slot, committed set.
    int          cyc;
    logic        m_pend;
    logic [15:0] p_hex, c_hex;
    logic [3:0]  p_dp, p_bl, p_bk, c_dp, c_bl, c_bk;
    logic [31:0] exp_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 0;
            m_pend   <= 1'b0;
            p_hex    <= '0; p_dp <= '0; p_bl <= 4'hF; p_bk <= '0;
            c_hex    <= '0; c_dp <= '0; c_bl <= 4'hF; c_bk <= '0;
            exp_data <= 32'hFFFF_FFFF;
        end else begin
            cyc      <= cyc + 1;
            exp_data <= encode(c_hex, c_dp, c_bl, c_bk, 1'((cyc / FLASH_HALF) % 2));
            if (wr_en && !m_pend) begin
                m_pend <= 1'b1;
                p_hex  <= wr_data; p_dp <= wr_dp; p_bl <= wr_blank; p_bk <= wr_blink;
            end else if ((cyc % FRAME == FRAME - 1) && m_pend) begin
                m_pend <= 1'b0;
                c_hex  <= p_hex; c_dp <= p_dp; c_bl <= p_bl; c_bk <= p_bk;
            end
        end
    end

    task automatic do_reset;
        wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_write(input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] bl, input logic [3:0] bk);
        wr_en = 1'b1; wr_data = v; wr_dp = dp; wr_blank = bl; wr_blink = bk;
    endtask

    task automatic test_reset;
        do_reset;
        for (int n = 0; n < 37; n++) @(negedge clk);
        drive_write(16'h4321, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (flash !== 1'b1) begin
            errors++; $display("FAIL reset_pre_flash: got %b expected 1", flash);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (scan !== 2'd0) begin errors++; $display("FAIL reset_scan: got %0d expected 0", scan); end
        checks++;
        if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b expected 0", flash); end
        checks++;
        if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data: got %h expected ffffffff", data); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan;
        logic [1:0] es;
        logic       ef;
        do_reset;
        for (int n = 0; n < 70; n++) begin
            es = 2'((n / SD) % 4);
            ef = 1'((n / FLASH_HALF) % 2);
            checks++;
            if (scan !== es) begin errors++; $display("FAIL scan_walk n=%0d: got %0d expected %0d", n, scan, es); end
            checks++;
            if (flash !== ef) begin errors++; $display("FAIL flash_walk n=%0d: got %b expected %b", n, flash, ef); end
            @(negedge clk);
        end
    endtask

    task automatic test_write;
        logic        er;
        logic [31:0] ed;
        do_reset;
        for (int n = 0; n <= 20; n++) begin
            er = !((n >= 6) && (n <= 15));
            ed = (n >= 17) ? 32'h99B0A4F9 : 32'hFFFF_FFFF;
            checks++;
            if (wr_ready !== er) begin errors++; $display("FAIL write_ready n=%0d: got %b expected %b", n, wr_ready, er); end
            checks++;
            if (data !== ed) begin errors++; $display("FAIL write_data n=%0d: got %h expected %h", n, data, ed); end
            if (n == 5) drive_write(16'h1234, 4'h0, 4'h0, 4'h0);
            else        wr_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_dp_blank;
        do_reset;
        for (int n = 0; n <= 19; n++) begin
            if (n >= 17) begin
                checks++;
                if (data !== 32'h19B0A4FF) begin errors++; $display("FAIL dp_blank n=%0d: got %h expected 19b0a4ff", n, data); end
            end
            checks++;
            if (data !== exp_data) begin errors++; $display("FAIL dp_blank_model n=%0d: got %h expected %h", n, data, exp_data); end
            if (n == 2) drive_write(16'h1234, 4'b0001, 4'b1000, 4'b0000);
            else        wr_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic        er;
        logic [31:0] ed;
        do_reset;
        for (int n = 0; n <= 70; n++) begin
            er = !(((n >= 1) && (n <= 15)) || ((n >= 48) && (n <= 63)));
            if (n < 17)       ed = 32'hFFFF_FFFF;
            else if (n < 65)  ed = {8'h99, (((n - 1) / FLASH_HALF) % 2 == 1) ? 8'hFF : 8'hB0, 8'hA4, 8'hF9};
            else              ed = 32'hA1C68388;
            checks++;
            if (wr_ready !== er) begin errors++; $display("FAIL b2b_ready n=%0d: got %b expected %b", n, wr_ready, er); end
            checks++;
            if (data !== ed) begin errors++; $display("FAIL b2b_data n=%0d: got %h expected %h", n, data, ed); end
            if (n == 0)       drive_write(16'h1234, 4'h0, 4'h0, 4'b0010);
            else if (n == 1)  drive_write(16'h5678, 4'h0, 4'h0, 4'h0);
            else if (n == 47) drive_write(16'hABCD, 4'h0, 4'h0, 4'h0);
            else              wr_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_pending;
        do_reset;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) drive_write(16'hFEDC, 4'h0, 4'h0, 4'h0);
            else        wr_en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL rp_pending: got %b expected 0", wr_ready); end
        do_reset;
        for (int n = 0; n < 40; n++) begin
            checks++;
            if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rp_data n=%0d: got %h expected ffffffff", n, data); end
            checks++;
            if (wr_ready !== 1'b1) begin errors++; $display("FAIL rp_ready n=%0d: got %b expected 1", n, wr_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [1:0] es;
        logic       ef;
        do_reset;
        for (int n = 0; n < 400; n++) begin
            es = 2'((cyc / SD) % 4);
            ef = 1'((cyc / FLASH_HALF) % 2);
            checks++;
            if (data !== exp_data) begin errors++; $display("FAIL rand_data n=%0d: got %h expected %h", n, data, exp_data); end
            checks++;
            if (wr_ready !== !m_pend) begin errors++; $display("FAIL rand_ready n=%0d: got %b expected %b", n, wr_ready, !m_pend); end
            checks++;
            if (scan !== es) begin errors++; $display("FAIL rand_scan n=%0d: got %0d expected %0d", n, scan, es); end
            checks++;
            if (flash !== ef) begin errors++; $display("FAIL rand_flash n=%0d: got %b expected %b", n, flash, ef); end
            wr_en    = ($urandom % 4) == 0;
            wr_data  = 16'($urandom);
            wr_dp    = 4'($urandom);
            wr_blank = 4'($urandom & $urandom);
            wr_blink = 4'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_scan;
        test_write;
        test_dp_blank;
        test_back_to_back;
        test_reset_pending;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
